// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register file: NUM_REGS x 32-bit registers, independent write (AW/W in any order) and read FSMs,
// one outstanding transaction per direction; response 1 cycle after the last handshake, held until bready/rready.
module axi4_lite_slave_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                    r_en;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [LANES-1:0]        r_wstrb;
  logic [1:0]              r_bresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;

  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [LANES-1:0]        w_wr_strb;
  logic                    w_wr_oor, w_rd_oor;
  logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;
  logic                    w_unused;

  assign w_unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0], r_awaddr[1:0]};

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  assign w_commit = (r_wstate == W_IDLE      && w_aw_hs && w_w_hs) ||
                    (r_wstate == W_WAIT_DATA && w_w_hs) ||
                    (r_wstate == W_WAIT_ADDR && w_aw_hs);

  // Whichever half arrived earlier comes from its holding register.
  assign w_wr_addr = (r_wstate == W_WAIT_DATA) ? r_awaddr : awaddr;
  assign w_wr_data = (r_wstate == W_WAIT_ADDR) ? r_wdata  : wdata;
  assign w_wr_strb = (r_wstate == W_WAIT_ADDR) ? r_wstrb  : wstrb;

  assign w_wr_idx = w_wr_addr[2 +: IDX_W];
  assign w_rd_idx = araddr[2 +: IDX_W];
  assign w_wr_oor = (w_wr_addr >> (IDX_W + 2)) != '0;
  assign w_rd_oor = (araddr >> (IDX_W + 2)) != '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en     <= 1'b0;
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_en     <= 1'b1;
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
        else if (w_aw_hs)      w_wstate_nxt = W_WAIT_DATA;
        else if (w_w_hs)       w_wstate_nxt = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_w_hs)  w_wstate_nxt = W_RESP;
      W_WAIT_ADDR: if (w_aw_hs) w_wstate_nxt = W_RESP;
      W_RESP:      if (bready)  w_wstate_nxt = W_IDLE;
      default:                  w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (rready)  w_rstate_nxt = R_IDLE;
      default:              w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    awready = r_en && (r_wstate == W_IDLE || r_wstate == W_WAIT_ADDR);
    wready  = r_en && (r_wstate == W_IDLE || r_wstate == W_WAIT_DATA);
    bvalid  = (r_wstate == W_RESP);
    arready = r_en && (r_rstate == R_IDLE);
    rvalid  = (r_rstate == R_DATA);
  end

  assign bresp = r_bresp;
  assign rdata = r_rdata;
  assign rresp = r_rresp;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= 2'b00;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) begin
        r_bresp <= w_wr_oor ? 2'b10 : 2'b00;
        if (!w_wr_oor) begin
          for (int i = 0; i < LANES; i++)
            if (w_wr_strb[i]) r_regs[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
      // Non-blocking read of r_regs gives the pre-write value on a same-edge collision.
      if (w_ar_hs) begin
        r_rdata <= w_rd_oor ? '0 : r_regs[w_rd_idx];
        r_rresp <= w_rd_oor ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile: one task per scenario, inline checks, single summary line.
module tb_axi4_lite_slave_regfile;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi4_lite_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Drives AW and W together; returns bvalid/bresp seen the cycle after the handshake.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic bv, output logic [1:0] br);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(awready && wready) && n < 20) begin tick; n++; end
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    bv = bvalid; br = bresp;
    tick;
  endtask

  // Returns rvalid/rdata/rresp seen the cycle after the AR handshake.
  task automatic do_read(input logic [31:0] a, output logic rv, output logic [31:0] d,
                         output logic [1:0] r);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    while (!arready && n < 20) begin tick; n++; end
    tick;
    arvalid = 1'b0;
    rv = rvalid; d = rdata; r = rresp;
    rready = 1'b1;
    tick;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1'b1; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    repeat (5) tick;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      n_fail++; $display("FAIL reset_payload: bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    aresetn = 1'b1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_first_cycle: readies=%b want 000", {awready, wready, arready});
    end
    tick;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_second_cycle: readies=%b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle;
    logic bv, rv; logic [1:0] br, rr; logic [31:0] d;
    do_write(32'h08, 32'hDEADBEEF, 4'hF, bv, br);
    n_checks++;
    if ({bv, br} !== 3'b100) begin
      n_fail++; $display("FAIL aw_w_bresp: bvalid=%b bresp=%b want 1 00", bv, br);
    end
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL aw_w_bvalid_drop: bvalid=%b want 0", bvalid);
    end
    do_read(32'h08, rv, d, rr);
    n_checks++;
    if ({rv, rr, d} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL aw_w_readback: rvalid=%b rresp=%b rdata=%h want 1 00 deadbeef", rv, rr, d);
    end
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rvalid_drop: rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_w_before_aw;
    logic bv, rv; logic [1:0] br, rr; logic [31:0] d;
    do_write(32'h04, 32'hAABBCCDD, 4'hF, bv, br);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        n_fail++; $display("FAIL w_first_hold[%0d]: wready/awready/bvalid=%b want 010", i, {wready, awready, bvalid});
      end
      if (i < 2) tick;
    end
    wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    awaddr = 32'h04; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    n_checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      n_fail++; $display("FAIL w_first_bresp: bvalid=%b bresp=%b want 1 00", bvalid, bresp);
    end
    tick;
    do_read(32'h04, rv, d, rr);
    n_checks++;
    if (d !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL strobe_merge: rdata=%h want aa22cc44", d);
    end
  endtask

  task automatic test_out_of_range;
    logic bv, rv; logic [1:0] br, rr; logic [31:0] d;
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, bv, br);
    n_checks++;
    if ({bv, br} !== 3'b110) begin
      n_fail++; $display("FAIL oor_bresp: bvalid=%b bresp=%b want 1 10", bv, br);
    end
    do_read(32'h00, rv, d, rr);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL oor_no_alias: reg0=%h want 00000000", d);
    end
    do_read(32'h08, rv, d, rr);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL oor_reg2_kept: reg2=%h want deadbeef", d);
    end
    do_read(32'h40, rv, d, rr);
    n_checks++;
    if ({rv, rr, d} !== {1'b1, 2'b10, 32'h0}) begin
      n_fail++; $display("FAIL oor_read: rvalid=%b rresp=%b rdata=%h want 1 10 0", rv, rr, d);
    end
    do_write(32'h08, 32'h0, 4'h0, bv, br);
    do_read(32'h08, rv, d, rr);
    n_checks++;
    if ({br, d} !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL zero_strobe: bresp=%b rdata=%h want 00 deadbeef", br, d);
    end
  endtask

  task automatic test_backpressure;
    bready = 1'b0;
    awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awaddr = 32'h0C; wdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        n_fail++; $display("FAIL b_backpressure[%0d]: bvalid/bresp/awready/wready=%b want 10000", i, {bvalid, bresp, awready, wready});
      end
      tick;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick;
    n_checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++; $display("FAIL b_release: bvalid/awready/wready=%b want 011", {bvalid, awready, wready});
    end
    rready = 1'b0; araddr = 32'h0C; arvalid = 1'b1;
    tick;
    araddr = 32'h08;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rvalid, rresp, arready, rdata} !== {1'b1, 2'b00, 1'b0, 32'h12345678}) begin
        n_fail++; $display("FAIL r_backpressure[%0d]: rvalid=%b rresp=%b arready=%b rdata=%h want 1 00 0 12345678", i, rvalid, rresp, arready, rdata);
      end
      tick;
    end
    arvalid = 1'b0; rready = 1'b1;
    tick;
    rready = 1'b0;
    n_checks++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++; $display("FAIL r_release: rvalid/arready=%b want 01", {rvalid, arready});
    end
  endtask

  task automatic test_same_edge;
    logic bv, rv; logic [1:0] br, rr; logic [31:0] d;
    do_write(32'h08, 32'h1, 4'hF, bv, br);
    awaddr = 32'h08; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_checks++;
    if ({bvalid, rvalid, rdata} !== {1'b1, 1'b1, 32'h1}) begin
      n_fail++; $display("FAIL same_edge_old: bvalid=%b rvalid=%b rdata=%h want 1 1 00000001", bvalid, rvalid, rdata);
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
    do_read(32'h08, rv, d, rr);
    n_checks++;
    if (d !== 32'h5) begin
      n_fail++; $display("FAIL same_edge_new: rdata=%h want 00000005", d);
    end
  endtask

  task automatic test_reset_midflight;
    logic rv; logic [1:0] rr; logic [31:0] d;
    logic seen_b = 1'b0;
    awaddr = 32'h08; awvalid = 1'b1; bready = 1'b1;
    tick;
    awvalid = 1'b0;
    n_checks++;
    if ({awready, wready, bvalid} !== 3'b010) begin
      n_fail++; $display("FAIL wait_data_state: awready/wready/bvalid=%b want 010", {awready, wready, bvalid});
    end
    aresetn = 1'b0;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    repeat (3) begin tick; seen_b |= bvalid; end
    wvalid = 1'b0;
    aresetn = 1'b1;
    repeat (3) begin tick; seen_b |= bvalid; end
    n_checks++;
    if (seen_b !== 1'b0) begin
      n_fail++; $display("FAIL midflight_bvalid: bvalid rose=%b want 0", seen_b);
    end
    do_read(32'h08, rv, d, rr);
    n_checks++;
    if ({rv, rr, d} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++; $display("FAIL midflight_reg2: rvalid=%b rresp=%b rdata=%h want 1 00 0", rv, rr, d);
    end
  endtask

  initial begin
    test_reset;
    test_write_same_cycle;
    test_w_before_aw;
    test_out_of_range;
    test_backpressure;
    test_same_edge;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
